// File: rtl/seq_detect_pkg.sv
// Shared defaults, mode encoding and config helper
// for the Mealy sequence detector.
package seq_detect_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  function automatic logic len_ok(
    input int unsigned len,
    input int unsigned max_len
  );
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_detect_mealy_sat_counter.sv
// Saturating event counter; a clear that coincides
// with an increment restarts the count at one.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_clr) begin
      w_nxt = i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && !r_sat) begin
      w_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_nxt;
      r_sat <= &w_nxt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

// File: rtl/seq_detect_mealy.sv
// Programmable Mealy sequence detector with overlap
// control and a saturating match counter.
module seq_detect_mealy
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             w_valid,
  input  logic             w,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             mode_overlap,
  input  logic             cfg_load,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  // The oldest history bit never reaches the compare
  // window, so only PAT_W-1 bits are stored.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_z;
  logic             r_cfg_err;

  logic [PAT_W-1:0] w_cand;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W:0]   w_fill_p1;
  logic             w_err_now;
  logic             w_fill_ok;
  logic             w_hit;
  logic             w_step;
  logic             w_match;
  logic             w_restart;
  logic [LEN_W-1:0] w_fill_nxt;

  assign w_cand = {r_hist, w};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(32'(pat_len)));
    end
  end

  assign w_err_now = !len_ok(32'(pat_len), PAT_W);
  assign w_fill_p1 = {1'b0, r_fill} + (LEN_W+1)'(1);
  assign w_fill_ok = w_fill_p1 >= {1'b0, pat_len};
  assign w_hit     = ((w_cand ^ pattern) & w_mask) == '0;
  assign w_step    = w_valid && !cfg_load;

  assign w_match = w_step && !w_err_now
                && w_fill_ok && w_hit;

  assign w_restart = w_match
    && (mode_e'(mode_overlap) == MODE_NONOVL);

  always_comb begin
    w_fill_nxt = r_fill;
    if (cfg_load) begin
      w_fill_nxt = '0;
    end else if (w_valid) begin
      if (w_restart) begin
        w_fill_nxt = '0;
      end else if (r_fill != FILL_MAX) begin
        w_fill_nxt = w_fill_p1[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
    end else if (cfg_load) begin
      r_hist <= '0;
    end else if (w_valid) begin
      r_hist <= w_cand[PAT_W-2:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fill    <= '0;
      r_z       <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_fill    <= w_fill_nxt;
      r_z       <= w_match;
      r_cfg_err <= w_err_now;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clock),
    .rst   (reset),
    .i_clr (cnt_clr),
    .i_inc (w_match),
    .o_cnt (match_cnt),
    .o_sat (cnt_sat)
  );

  assign z       = r_z;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed bench for seq_detect_mealy with a queue-based
// reference model and per-cycle output comparison.
module tb_seq_detect_mealy;

  localparam int PAT_W  = 8;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 16;
  localparam int CNT_WB = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             w_valid;
  logic             w;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             mode_overlap;
  logic             cfg_load;
  logic             cnt_clr;

  logic              z, cnt_sat, cfg_err;
  logic [CNT_W-1:0]  match_cnt;
  logic              zb, cnt_satb, cfg_errb;
  logic [CNT_WB-1:0] match_cntb;

  always #5 clock = ~clock;

  seq_detect_mealy #(
    .PAT_W (PAT_W), .LEN_W (LEN_W), .CNT_W (CNT_W)
  ) u_dut (
    .clock (clock), .reset (reset),
    .w_valid (w_valid), .w (w),
    .pattern (pattern), .pat_len (pat_len),
    .mode_overlap (mode_overlap),
    .cfg_load (cfg_load), .cnt_clr (cnt_clr),
    .z (z), .match_cnt (match_cnt),
    .cnt_sat (cnt_sat), .cfg_err (cfg_err)
  );

  seq_detect_mealy #(
    .PAT_W (PAT_W), .LEN_W (LEN_W), .CNT_W (CNT_WB)
  ) u_dut_b (
    .clock (clock), .reset (reset),
    .w_valid (w_valid), .w (w),
    .pattern (pattern), .pat_len (pat_len),
    .mode_overlap (mode_overlap),
    .cfg_load (cfg_load), .cnt_clr (cnt_clr),
    .z (zb), .match_cnt (match_cntb),
    .cnt_sat (cnt_satb), .cfg_err (cfg_errb)
  );

  int n_chk = 0;
  int n_err = 0;

  bit raw_q[$];
  int live;
  bit exp_z, exp_err;
  int exp_cnt, exp_cntb;
  bit chk_en = 1'b0;

  localparam int MAX_A = (1 << CNT_W) - 1;
  localparam int MAX_B = (1 << CNT_WB) - 1;

  function automatic void check(string nm,
    logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    raw_q.delete();
    live     = 0;
    exp_z    = 1'b0;
    exp_err  = 1'b0;
    exp_cnt  = 0;
    exp_cntb = 0;
  endfunction

  // Match = the newest len stream bits since the last
  // restart equal the low len bits of the pattern.
  function automatic void model_step();
    int len = int'(pat_len);
    bit err = (len == 0) || (len > PAT_W);
    bit m = 1'b0;
    if (cfg_load) begin
      raw_q.delete();
      live = 0;
    end else if (w_valid) begin
      raw_q.push_back(w);
      if (raw_q.size() > PAT_W) void'(raw_q.pop_front());
      if (!err && (live + 1 >= len)) begin
        m = 1'b1;
        for (int k = 0; k < len; k++)
          if (raw_q[raw_q.size()-1-k] != pattern[k]) m = 1'b0;
      end
      live = (live + 1 > PAT_W) ? PAT_W : live + 1;
      if (m && !mode_overlap) live = 0;
    end
    exp_z   = m;
    exp_err = err;
    if (cnt_clr) begin
      exp_cnt  = m ? 1 : 0;
      exp_cntb = m ? 1 : 0;
    end else if (m) begin
      if (exp_cnt < MAX_A) exp_cnt++;
      if (exp_cntb < MAX_B) exp_cntb++;
    end
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      check("z", 32'(z), 32'(exp_z));
      check("match_cnt", 32'(match_cnt), 32'(exp_cnt));
      check("cnt_sat", 32'(cnt_sat), 32'(exp_cnt == MAX_A));
      check("cfg_err", 32'(cfg_err), 32'(exp_err));
      check("z_b", 32'(zb), 32'(exp_z));
      check("match_cnt_b", 32'(match_cntb), 32'(exp_cntb));
      check("cnt_sat_b", 32'(cnt_satb), 32'(exp_cntb == MAX_B));
      check("cfg_err_b", 32'(cfg_errb), 32'(exp_err));
    end
  end

  task automatic drive(input bit v, input bit b,
    input bit ld, input bit clr, output bit zo);
    @(negedge clock);
    w_valid  = v;
    w        = b;
    cfg_load = ld;
    cnt_clr  = clr;
    @(posedge clock);
    model_step();
    #1 zo = z;
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p,
    input logic [LEN_W-1:0] l, input bit o);
    @(negedge clock);
    pattern      = p;
    pat_len      = l;
    mode_overlap = o;
    w_valid      = 1'b0;
    w            = 1'b0;
    cfg_load     = 1'b1;
    cnt_clr      = 1'b1;
    @(posedge clock);
    model_step();
    #1;
  endtask

  // bits[n-1] is sent first; zs[i] is z after bits[i]
  task automatic send_bits(input logic [15:0] bits,
    input int n, output logic [15:0] zs);
    bit zo;
    zs = '0;
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, bits[i], 1'b0, 1'b0, zo);
      zs[i] = zo;
    end
  endtask

  logic [15:0] zs;
  bit zo, gz;

  initial begin
    reset = 1'b1;
    w_valid = 1'b0; w = 1'b0;
    pattern = '0; pat_len = '0; mode_overlap = 1'b0;
    cfg_load = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_z", 32'(z), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_sat", 32'(cnt_sat), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // legacy "11" detector
    cfg(8'b11, 4'd2, 1'b1);
    send_bits(16'b0111011, 7, zs);
    check("t1_z", 32'(zs[6:0]), 32'b0011001);
    check("t1_cnt", 32'(match_cnt), 32'd3);

    // 101 non-overlap vs overlap
    cfg(8'b101, 4'd3, 1'b0);
    send_bits(16'b10101, 5, zs);
    check("t2_nonovl_z", 32'(zs[4:0]), 32'b00100);
    check("t2_nonovl_cnt", 32'(match_cnt), 32'd1);
    cfg(8'b101, 4'd3, 1'b1);
    send_bits(16'b10101, 5, zs);
    check("t2_ovl_z", 32'(zs[4:0]), 32'b00101);
    check("t2_ovl_cnt", 32'(match_cnt), 32'd2);

    // 1101 with valid gaps
    cfg(8'b1101, 4'd4, 1'b1);
    gz = 1'b0;
    drive(1, 1, 0, 0, zo);
    drive(0, 0, 0, 0, zo); gz |= zo;
    drive(1, 1, 0, 0, zo);
    drive(0, 1, 0, 0, zo); gz |= zo;
    drive(0, 0, 0, 0, zo); gz |= zo;
    drive(1, 0, 0, 0, zo);
    drive(0, 1, 0, 0, zo); gz |= zo;
    drive(1, 1, 0, 0, zo);
    check("t3_last_z", 32'(zo), 32'd1);
    drive(0, 1, 0, 0, zo); gz |= zo;
    check("t3_gap_z", 32'(gz), 32'd0);

    // cfg_load discards partial history
    cfg(8'b1101, 4'd4, 1'b1);
    send_bits(16'b110, 3, zs);
    drive(1, 1, 1, 0, zo);
    drive(1, 1, 0, 0, zo);
    check("t4_after_load_z", 32'(zo), 32'd0);
    send_bits(16'b1101, 4, zs);
    check("t4_full_z", 32'(zs[3:0]), 32'b0001);

    // saturation on the 2-bit counter
    cfg(8'b11, 4'd2, 1'b0);
    send_bits(16'b11111111, 8, zs);
    check("t5_z", 32'(zs[7:0]), 32'b01010101);
    check("t5_cnt_b", 32'(match_cntb), 32'd3);
    check("t5_sat_b", 32'(cnt_satb), 32'd1);
    check("t5_cnt_a", 32'(match_cnt), 32'd4);
    drive(1, 1, 0, 0, zo);
    drive(1, 1, 0, 1, zo);
    check("t5_clr_match_a", 32'(match_cnt), 32'd1);
    check("t5_clr_match_b", 32'(match_cntb), 32'd1);

    // illegal lengths
    cfg(8'b11, 4'd0, 1'b1);
    send_bits(16'b1111, 4, zs);
    check("t6_len0_z", 32'(zs[3:0]), 32'd0);
    check("t6_len0_err", 32'(cfg_err), 32'd1);
    cfg(8'b11, 4'd9, 1'b1);
    send_bits(16'b1111, 4, zs);
    check("t6_len9_z", 32'(zs[3:0]), 32'd0);
    check("t6_len9_err", 32'(cfg_err), 32'd1);

    // reset mid-pattern
    cfg(8'b1101, 4'd4, 1'b1);
    send_bits(16'b1101110, 7, zs);
    check("t6_pre_z", 32'(zs[6:0]), 32'b0001000);
    check("t6_pre_cnt", 32'(match_cnt), 32'd1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("t6_rst_z", 32'(z), 32'd0);
    check("t6_rst_cnt", 32'(match_cnt), 32'd0);
    #1 reset = 1'b0;
    drive(1, 1, 0, 0, zo);
    check("t6_post_z", 32'(zo), 32'd0);
    send_bits(16'b1101, 4, zs);
    check("t6_post_full_z", 32'(zs[3:0]), 32'b0001);

    drive(0, 0, 0, 0, zo);
    @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
